// File: rtl/mem.sv
// Word-organised data memory for the MIPS MEM stage.
// Byte-addressed 32-bit port. Writes happen on the clock edge, reads are
// combinational, and err flags misaligned, out-of-range or conflicting accesses.
module mem #(
  parameter int DEPTH = 64
) (
  output logic [31:0] memOut,
  input  logic [31:0] address,
  input  logic [31:0] memIn,
  input  logic        clk,
  input  logic        read,
  input  logic        write,
  input  logic        reset,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] w_idx;
  logic          w_aligned;
  logic          w_in_range;
  logic          w_legal;
  logic          w_rd_ok;
  logic          w_wr_ok;

  // Decode the word index and qualify the access.
  always_comb begin
    w_idx      = address[AW+1:2];
    w_aligned  = (address[1:0] == 2'b00);
    // DEPTH is a power of two, so address < DEPTH*4 is the same as every
    // bit above the index being zero. Addresses are never wrapped or aliased.
    w_in_range = (address[31:AW+2] == '0);
    w_legal    = w_aligned && w_in_range && !(read && write);
    w_rd_ok    = read && !write && w_legal;
    w_wr_ok    = write && !read && w_legal;
    err        = (read || write) && !w_legal;
  end

  // Clear every word on reset. Otherwise write one word on a legal store.
  // NOTE: a reset that clears the whole array rules out a block-RAM mapping.
  // The behaviour calls for it, so the storage is built as registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: sequential state uses non-blocking assignments only, so that
        // every reader sees the values from before the edge.
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[w_idx] <= memIn;
    end
  end

  // Combinational read. The output is zero unless a legal read is in progress.
  always_comb begin
    // NOTE: assigning a default first keeps this block from inferring a latch.
    memOut = '0;
    if (w_rd_ok) begin
      memOut = r_mem[w_idx];
    end
  end

endmodule

// File: tb/tb_mem.sv
// Self-checking bench for mem. It runs directed steps from the test plan and
// then random accesses. Expected values come from a word-array reference model.
module tb_mem;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [31:0] memIn;
  logic [31:0] memOut;
  logic        err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [DEPTH];

  mem #(.DEPTH(DEPTH)) dut (
    .memOut (memOut),
    .address(address),
    .memIn  (memIn),
    .clk    (clk),
    .read   (read),
    .write  (write),
    .reset  (reset),
    .err    (err)
  );

  always #5 clk = ~clk;

  function automatic bit legal(input bit r, input bit w, input logic [31:0] a);
    return (a % 4 == 0) && (a < DEPTH * 4) && !(r && w);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs in the low phase of the clock and let the combinational paths settle.
  task automatic drive(input bit rst, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
    reset   = rst;
    read    = r;
    write   = w;
    address = a;
    memIn   = d;
    #1;
  endtask

  // Compare memOut and err with the values the model derives from the access rules.
  task automatic check_model(input string tag);
    logic [31:0] exp_out;
    logic [31:0] exp_err;
    bit          ok;
    ok      = legal(read, write, address);
    exp_out = (read && !write && ok) ? model[int'(address >> 2)] : 32'h0;
    exp_err = {31'b0, (read || write) && !ok};
    check({tag, "_out"}, memOut, exp_out);
    check({tag, "_err"}, {31'b0, err}, exp_err);
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    end else if (write && !read && legal(read, write, address)) begin
      model[int'(address >> 2)] = memIn;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    bit          r;
    bit          w;
    int          k;

    // Reset for one cycle. Then reads at the low, next and top word must all return 0.
    drive(1, 0, 0, 32'h0, 32'h0);
    tick();
    drive(0, 1, 0, 32'd0, 32'h0);
    check("rst_rd0", memOut, 32'h0);
    check_model("rst_rd0");
    tick();
    drive(0, 1, 0, 32'd4, 32'h0);
    check("rst_rd4", memOut, 32'h0);
    check_model("rst_rd4");
    tick();
    drive(0, 1, 0, (DEPTH - 1) * 4, 32'h0);
    check("rst_rd_top", memOut, 32'h0);
    check("rst_rd_top_err", {31'b0, err}, 32'h0);
    tick();

    // Two writes, then reads that include the unwritten word between them.
    drive(0, 0, 1, 32'd16, 32'h12345678);
    check("wr16_err", {31'b0, err}, 32'h0);
    check("wr16_out", memOut, 32'h0);
    tick();
    drive(0, 0, 1, 32'd24, 32'h89abcdef);
    check_model("wr24");
    tick();
    drive(0, 1, 0, 32'd16, 32'h0);
    check("rd16", memOut, 32'h12345678);
    check_model("rd16");
    tick();
    drive(0, 1, 0, 32'd20, 32'h0);
    check("rd20", memOut, 32'h0);
    tick();
    drive(0, 1, 0, 32'd24, 32'h0);
    check("rd24", memOut, 32'h89abcdef);
    tick();

    // Misaligned and out-of-range writes set err and leave memory unchanged.
    drive(0, 0, 1, 32'd18, 32'hDEADBEEF);
    check("wr_unal_err", {31'b0, err}, 32'h1);
    tick();
    drive(0, 0, 1, DEPTH * 4, 32'hDEADBEEF);
    check("wr_oor_err", {31'b0, err}, 32'h1);
    tick();
    drive(0, 1, 0, 32'd16, 32'h0);
    check("rd16_after_bad", memOut, 32'h12345678);
    tick();
    drive(0, 1, 0, (DEPTH - 1) * 4, 32'h0);
    check("rd_top_after_bad", memOut, 32'h0);
    tick();
    drive(0, 1, 0, DEPTH * 4, 32'h0);
    check("rd_oor_out", memOut, 32'h0);
    check("rd_oor_err", {31'b0, err}, 32'h1);
    tick();

    // A simultaneous read and write is illegal, and the stored word survives it.
    drive(0, 0, 1, 32'd8, 32'h00005555);
    tick();
    drive(0, 1, 1, 32'd8, 32'hFFFFFFFF);
    check("rw_err", {31'b0, err}, 32'h1);
    check("rw_out", memOut, 32'h0);
    tick();
    drive(0, 1, 0, 32'd8, 32'h0);
    check("rd8_after_rw", memOut, 32'h00005555);
    tick();

    // Reset takes priority over a write in the same cycle and clears earlier writes.
    drive(0, 0, 1, 32'd40, 32'hCAFEF00D);
    tick();
    drive(0, 1, 0, 32'd40, 32'h0);
    check("rd40_pre_rst", memOut, 32'hCAFEF00D);
    tick();
    drive(1, 0, 1, 32'd44, 32'h11112222);
    tick();
    drive(0, 1, 0, 32'd40, 32'h0);
    check("rd40_post_rst", memOut, 32'h0);
    tick();
    drive(0, 1, 0, 32'd44, 32'h0);
    check("rd44_post_rst", memOut, 32'h0);
    tick();
    drive(0, 1, 0, 32'd16, 32'h0);
    check("rd16_post_rst", memOut, 32'h0);
    tick();

    // An idle cycle never flags an error. A read in the cycle after a write returns the new data.
    drive(0, 0, 0, 32'd3, 32'h0);
    check("idle_err", {31'b0, err}, 32'h0);
    check("idle_out", memOut, 32'h0);
    tick();
    drive(0, 0, 1, 32'd16, 32'hA5A5_5A5A);
    check("raw_wr_out", memOut, 32'h0);
    tick();
    drive(0, 1, 0, 32'd16, 32'h0);
    check("raw_rd", memOut, 32'hA5A5_5A5A);
    tick();

    // While reset is held high, a read returns 0 once the array has been cleared.
    drive(1, 1, 0, 32'd16, 32'h0);
    tick();
    drive(1, 1, 0, 32'd16, 32'h0);
    check("rst_held_rd", memOut, 32'h0);
    check_model("rst_held");
    tick();

    // Random accesses, mostly legal, with some misaligned, out-of-range and conflicting ones.
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 99);
      a = $urandom_range(0, DEPTH - 1) * 4;
      if (k < 8)       a = a | $urandom_range(1, 3);
      else if (k < 14) a = $urandom;
      else if (k < 17) a = DEPTH * 4 + $urandom_range(0, 15) * 4;
      r = ($urandom_range(0, 9) < 5);
      w = ($urandom_range(0, 9) < 5);
      drive(($urandom_range(0, 59) == 0), r, w, a, $urandom);
      check_model("rand");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
